ca_despreader: RTL and testbench

CA_DESPREADER -- requirements
Module: ca_despreader

---
 rtl/ca_despread_pkg.sv | 18 +
 rtl/ca_despread_peak.sv | 49 ++++
 rtl/ca_despreader.sv | 129 ++++++++++++
 tb/tb_ca_despreader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_despread_pkg.sv
// Shared types and constants for the C/A code despreader (state encoding, default
// integration length and accumulator sizing helper).
package ca_despread_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_INT_LEN = 1023;

  // Minimum signed width that can hold +/-int_len.
  function automatic int acc_w_min(input int int_len);
    return $clog2(int_len + 1) + 1;
  endfunction

endpackage

// File: rtl/ca_despread_peak.sv
// Peak tracker: keeps the largest |correlation| loaded since start and the dump
// index at which it occurred. Only built when CA_DESPREADER_PEAK_EN is defined.
module ca_despread_peak #(
  parameter int ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_dump,
  input  logic                    i_load,
  input  logic signed [ACC_W-1:0] i_corr,
  output logic [ACC_W-2:0]        o_peak,
  output logic [15:0]             o_idx
);

  function automatic logic [ACC_W-1:0] abs_mag(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? -v : v;
  endfunction

  logic [ACC_W-1:0] w_mag;
  logic [ACC_W-2:0] r_peak;
  logic [15:0]      r_idx;
  logic [15:0]      r_dump_idx;

  assign w_mag = abs_mag(i_corr);

  // Strict compare so a tie keeps the earlier dump index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak     <= '0;
      r_idx      <= '0;
      r_dump_idx <= '0;
    end else if (i_clear) begin
      r_peak     <= '0;
      r_idx      <= '0;
      r_dump_idx <= '0;
    end else begin
      if (i_load && (w_mag > {1'b0, r_peak})) begin
        r_peak <= w_mag[ACC_W-2:0];
        r_idx  <= r_dump_idx;
      end
      if (i_dump) r_dump_idx <= r_dump_idx + 16'd1;
    end
  end

  assign o_peak = r_peak;
  assign o_idx  = r_idx;

endmodule

// File: rtl/ca_despreader.sv
// C/A code despreader: integrates +/-1 agreement between received and replica chips
// over INT_LEN samples and hands off the sum. Optional peak tracking: CA_DESPREADER_PEAK_EN.
module ca_despreader
  import ca_despread_pkg::*;
#(
  parameter int INT_LEN = DEFAULT_INT_LEN,
  parameter int ACC_W   = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_in,
  input  logic                    code_in,
  input  logic                    sample_en,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    abort,
  output logic signed [ACC_W-1:0] corr_out,
  output logic                    corr_valid,
  input  logic                    corr_ready,
  output logic                    busy,
  output logic                    overrun
`ifdef CA_DESPREADER_PEAK_EN
  ,
  output logic [ACC_W-2:0]        peak_out,
  output logic [15:0]             peak_idx
`endif
);

  localparam int CNT_W = $clog2(INT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INT_LEN);

  state_e                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_corr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_cont;
  logic                    r_valid;
  logic                    r_overrun;

  logic signed [ACC_W-1:0] w_step;
  logic signed [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_start_acc;
  logic                    w_sample;
  logic                    w_dump;
  logic                    w_consume;
  logic                    w_load;

  assign w_step      = (sample_in == code_in) ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
  assign w_sum       = r_acc + w_step;
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_start_acc = (r_state == IDLE) && start;
  // abort wins over a coincident final sample
  assign w_sample    = (r_state == INTEG) && sample_en && !abort;
  assign w_dump      = w_sample && (w_cnt_nxt == LAST_CNT);
  assign w_consume   = r_valid && corr_ready;
  // A pending unconsumed result is never overwritten; the new sum is dropped instead.
  assign w_load      = w_dump && (!r_valid || corr_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_cont    <= 1'b0;
      r_corr    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_consume) r_valid <= 1'b0;
      if (w_load) begin
        r_corr  <= w_sum;
        r_valid <= 1'b1;
      end
      if (w_dump && !w_load) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_start_acc) begin
            r_state   <= INTEG;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_cont    <= cont;
            r_overrun <= 1'b0;
          end
        end
        INTEG: begin
          if (abort) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else if (w_dump) begin
            r_acc <= '0;
            r_cnt <= '0;
            if (!r_cont) r_state <= DONE;
          end else if (w_sample) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_nxt;
          end
        end
        DONE: begin
          if (w_consume) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign corr_out   = r_corr;
  assign corr_valid = r_valid;
  assign busy       = (r_state != IDLE);
  assign overrun    = r_overrun;

`ifdef CA_DESPREADER_PEAK_EN
  ca_despread_peak #(
    .ACC_W (ACC_W)
  ) u_peak (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start_acc),
    .i_dump  (w_dump),
    .i_load  (w_load),
    .i_corr  (w_sum),
    .o_peak  (peak_out),
    .o_idx   (peak_idx)
  );
`endif

endmodule

// File: tb/tb_ca_despreader.sv
// Self-checking bench for ca_despreader: table-driven integrations, randomized runs
// against a match-counting model, and hand-written handshake/abort/reset sequences.
module tb_ca_despreader;

  localparam int INT_LEN = 1023;
  localparam int ACC_W   = 12;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    sample_in, code_in, sample_en;
  logic                    start, cont, abort;
  logic signed [ACC_W-1:0] corr_out;
  logic                    corr_valid, corr_ready;
  logic                    busy, overrun;
`ifdef CA_DESPREADER_PEAK_EN
  logic [ACC_W-2:0]        peak_out;
  logic [15:0]             peak_idx;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int mode;
    int gap;
    int exp_corr;
  } vec_t;

  vec_t vt[4];

  ca_despreader #(
    .INT_LEN (INT_LEN),
    .ACC_W   (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .code_in    (code_in),
    .sample_en  (sample_en),
    .start      (start),
    .cont       (cont),
    .abort      (abort),
    .corr_out   (corr_out),
    .corr_valid (corr_valid),
    .corr_ready (corr_ready),
    .busy       (busy),
    .overrun    (overrun)
`ifdef CA_DESPREADER_PEAK_EN
    ,
    .peak_out   (peak_out),
    .peak_idx   (peak_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Whether chip i of a pattern agrees with the replica.
  function automatic bit pat(input int mode, input int i);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return (i % 2) == 0;
      3: return i < 600;
      4: return i < 514;
      5: return i < 61;
      6: return i < 962;
      default: return 1'b1;
    endcase
  endfunction

  // Feed n samples (indices first..first+n-1); mode 7 is random agreement with stray
  // start pulses, gap 3 is a random 0..2 idle cycles before each sample.
  task automatic feed_block(input int mode, input int first, input int n, input int gap,
                            inout int sum);
    for (int i = first; i < first + n; i++) begin
      bit m, c;
      int g;
      g = (gap == 3) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) tick();
      m = (mode == 7) ? bit'($urandom_range(0, 1)) : pat(mode, i);
      c = bit'($urandom_range(0, 1));
      sum += m ? 1 : -1;
      sample_in = m ? c : ~c;
      code_in   = c;
      sample_en = 1'b1;
      if (mode == 7 && $urandom_range(0, 15) == 0) begin
        start = 1'b1;
        cont  = 1'b1;
      end
      tick();
      sample_en = 1'b0;
      start     = 1'b0;
      cont      = 1'b0;
    end
  endtask

  task automatic integ_check(input string nm, input int mode, input int gap,
                             input int exp, input bit use_exp);
    int sum = 0;
    start = 1'b1; cont = 1'b0; tick(); start = 1'b0;
    check({nm, "_busy"}, busy, 1);
    feed_block(mode, 0, INT_LEN - 1, gap, sum);
    check({nm, "_early_valid"}, corr_valid, 0);
    feed_block(mode, INT_LEN - 1, 1, gap, sum);
    check({nm, "_valid"}, corr_valid, 1);
    check({nm, "_corr"}, corr_out, use_exp ? exp : sum);
    check({nm, "_done_busy"}, busy, 1);
    corr_ready = 1'b1; tick(); corr_ready = 1'b0;
    check({nm, "_consumed"}, corr_valid, 0);
    check({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    int sum;
    rst = 1'b1; sample_in = 0; code_in = 0; sample_en = 0;
    start = 0; cont = 0; abort = 0; corr_ready = 0;
    vt[0] = '{0, 0, 1023};
    vt[1] = '{1, 0, -1023};
    vt[2] = '{2, 2, 1};
    vt[3] = '{3, 0, 177};

    repeat (3) tick();
    check("rst_corr", corr_out, 0);
    check("rst_valid", corr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick();

    foreach (vt[k]) integ_check($sformatf("vec%0d", k), vt[k].mode, vt[k].gap, vt[k].exp_corr, 1'b1);
    for (int r = 0; r < 3; r++) integ_check($sformatf("rand%0d", r), 7, 3, 0, 1'b0);

    // start while DONE must be ignored
    sum = 0;
    start = 1'b1; tick(); start = 1'b0;
    feed_block(0, 0, INT_LEN, 0, sum);
    start = 1'b1; cont = 1'b1; tick(); start = 1'b0; cont = 1'b0;
    check("done_start_valid", corr_valid, 1);
    corr_ready = 1'b1; tick(); corr_ready = 0;
    tick();
    check("done_start_ignored", busy, 0);

    // continuous mode: dump, dump coinciding with consume, then dropped dump
    sum = 0;
    start = 1'b1; cont = 1'b1; tick(); start = 1'b0; cont = 1'b0;
    feed_block(0, 0, INT_LEN, 0, sum);
    check("cont_d1_valid", corr_valid, 1);
    check("cont_d1_corr", corr_out, 1023);
    check("cont_d1_busy", busy, 1);
    sum = 0;
    feed_block(1, 0, INT_LEN - 1, 0, sum);
    corr_ready = 1'b1;
    feed_block(1, INT_LEN - 1, 1, 0, sum);
    corr_ready = 1'b0;
    check("coinc_valid", corr_valid, 1);
    check("coinc_corr", corr_out, -1023);
    check("coinc_overrun", overrun, 0);
    sum = 0;
    feed_block(0, 0, INT_LEN, 0, sum);
    check("ovr_corr_kept", corr_out, -1023);
    check("ovr_valid", corr_valid, 1);
    check("ovr_flag", overrun, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_valid_kept", corr_valid, 1);
    check("abort_ovr_sticky", overrun, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("start_clr_ovr", overrun, 0);
    check("start_valid_kept", corr_valid, 1);
    corr_ready = 1'b1; tick(); corr_ready = 1'b0;
    check("integ_consume", corr_valid, 0);

    // abort coinciding with the final sample produces nothing
    sum = 0;
    feed_block(0, 0, INT_LEN - 1, 0, sum);
    abort = 1'b1;
    feed_block(0, INT_LEN - 1, 1, 0, sum);
    abort = 1'b0;
    check("abort_last_busy", busy, 0);
    check("abort_last_valid", corr_valid, 0);
    repeat (3) tick();
    check("abort_last_valid2", corr_valid, 0);
    check("abort_last_corr", corr_out, -1023);

    // asynchronous reset mid-integration
    sum = 0;
    start = 1'b1; tick(); start = 1'b0;
    feed_block(0, 0, 500, 0, sum);
    check("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_corr", corr_out, 0);
    check("arst_valid", corr_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    check("post_rst_valid", corr_valid, 0);
    check("post_rst_busy", busy, 0);
    integ_check("post_rst", 4, 0, 5, 1'b1);

`ifdef CA_DESPREADER_PEAK_EN
    begin
      int exp_c[3];
      int exp_p[3];
      int exp_i[3];
      exp_c = '{5, -901, 901};
      exp_p = '{5, 901, 901};
      exp_i = '{0, 1, 1};
      start = 1'b1; cont = 1'b1; tick(); start = 1'b0; cont = 1'b0;
      check("peak_clr_val", peak_out, 0);
      check("peak_clr_idx", peak_idx, 0);
      corr_ready = 1'b1;
      for (int d = 0; d < 3; d++) begin
        sum = 0;
        feed_block(4 + d, 0, INT_LEN, 0, sum);
        check($sformatf("peak_d%0d_corr", d), corr_out, exp_c[d]);
        check($sformatf("peak_d%0d_val", d), peak_out, exp_p[d]);
        check($sformatf("peak_d%0d_idx", d), peak_idx, exp_i[d]);
      end
      corr_ready = 1'b0;
      abort = 1'b1; tick(); abort = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      check("peak_restart_val", peak_out, 0);
      check("peak_restart_idx", peak_idx, 0);
      abort = 1'b1; tick(); abort = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
